// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter type and window helper.
// Used by vga_timing and vga_pix_en; the frame pulse option is VGA_TIMING_FRAME_PULSE_EN.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [CNT_W-1:0] count_t;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input count_t v, input count_t lo, input count_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_pix_en.sv
// Pixel-rate enable: divides the system clock by two as a one-in-two enable.
// Starts low in reset so the first cycle after release is an enabled one.
module vga_pix_en (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_pix_en
);

    logic r_pix_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    assign o_pix_en = r_pix_en;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel enable, h/v counters and combinational sync/bright decode.
// Define VGA_TIMING_FRAME_PULSE_EN to add the frameStart output.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pixEn,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    output logic             frameStart
`endif
);

    localparam int LINE_LEN  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LEN = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam count_t H_LAST    = count_t'(LINE_LEN - 1);
    localparam count_t H_VIS_END = count_t'(H_VISIBLE);
    localparam count_t HS_START  = count_t'(H_VISIBLE + H_FP);
    localparam count_t HS_END    = count_t'(H_VISIBLE + H_FP + H_SYNC);

    localparam count_t V_LAST    = count_t'(FRAME_LEN - 1);
    localparam count_t V_VIS_END = count_t'(V_VISIBLE);
    localparam count_t VS_START  = count_t'(V_VISIBLE + V_FP);
    localparam count_t VS_END    = count_t'(V_VISIBLE + V_FP + V_SYNC);

    logic   w_pix_en;
    count_t r_h_count;
    count_t r_v_count;

    vga_pix_en u_pix_en (
        .i_clk    (clk),
        .i_reset  (reset),
        .o_pix_en (w_pix_en)
    );

    // Wrap on >= rather than == so an out-of-range count can never persist.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_pix_en) begin
            if (r_h_count >= H_LAST) begin
                r_h_count <= '0;
                if (r_v_count >= V_LAST) begin
                    r_v_count <= '0;
                end else begin
                    r_v_count <= r_v_count + count_t'(1);
                end
            end else begin
                r_h_count <= r_h_count + count_t'(1);
            end
        end
    end

    assign pixEn  = w_pix_en;
    assign hCount = r_h_count;
    assign vCount = r_v_count;

    // Decode straight from the counter registers: zero latency vs hCount/vCount.
    assign hSync  = ~in_window(r_h_count, HS_START, HS_END);
    assign vSync  = ~in_window(r_v_count, VS_START, VS_END);
    assign bright = (r_h_count < H_VIS_END) && (r_v_count < V_VIS_END);

`ifdef VGA_TIMING_FRAME_PULSE_EN
    // Qualified by the enable so it is one clk wide even though the counters hold for two.
    assign frameStart = w_pix_en && (r_h_count == '0) && (r_v_count == V_VIS_END);
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-geometry DUT for reset/line/h-wrap checks,
// small-geometry DUT for frame-level counts, v-wrap and frameStart (VGA_TIMING_FRAME_PULSE_EN).
module tb_vga_timing;
    import vga_pkg::*;

    // Small geometry: line 32 (hsync 23..27), frame 17 lines (vsync 12..14), 1088 clk per frame.
    localparam int S_FRAME_CLK = 32 * 17 * 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic             rst_d = 1'b1;
    logic             rst_s = 1'b1;
    logic             pe_d, hs_d, vs_d, br_d;
    logic             pe_s, hs_s, vs_s, br_s;
    logic [CNT_W-1:0] h_d, v_d, h_s, v_s;
`ifdef VGA_TIMING_FRAME_PULSE_EN
    logic             fs_d, fs_s;
`endif

    int n_total = 0;
    int n_bad   = 0;

    vga_timing dut_d (
        .clk    (clk),
        .reset  (rst_d),
        .pixEn  (pe_d),
        .hCount (h_d),
        .vCount (v_d),
        .hSync  (hs_d),
        .vSync  (vs_d),
        .bright (br_d)
`ifdef VGA_TIMING_FRAME_PULSE_EN
        ,
        .frameStart (fs_d)
`endif
    );

    vga_timing #(
        .H_VISIBLE (20), .H_FP (3), .H_SYNC (5), .H_BP (4),
        .V_VISIBLE (10), .V_FP (2), .V_SYNC (3), .V_BP (2)
    ) dut_s (
        .clk    (clk),
        .reset  (rst_s),
        .pixEn  (pe_s),
        .hCount (h_s),
        .vCount (v_s),
        .hSync  (hs_s),
        .vSync  (vs_s),
        .bright (br_s)
`ifdef VGA_TIMING_FRAME_PULSE_EN
        ,
        .frameStart (fs_s)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   exp_h  [4] = '{0, 1, 1, 2};
        rst_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({pe_d, h_d, v_d, hs_d, vs_d, br_d} !== {1'b0, 10'd0, 10'd0, 3'b111}) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b, expected pe=0 h=0 v=0 hs=1 vs=1 br=1",
                         i, pe_d, h_d, v_d, hs_d, vs_d, br_d);
            end
`ifdef VGA_TIMING_FRAME_PULSE_EN
            n_total++;
            if (fs_d !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_frame_start: got %b expected 0", fs_d);
            end
`endif
        end
        rst_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (pe_d !== exp_pe[i] || h_d !== 10'(exp_h[i]) || v_d !== 10'd0) begin
                n_bad++;
                $display("FAIL release[%0d]: got pe=%b h=%0d v=%0d, expected pe=%b h=%0d v=0",
                         i, pe_d, h_d, v_d, exp_pe[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_hsync_line();
        int   bh     [6] = '{639, 640, 655, 656, 751, 752};
        logic exp_hs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_br [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int n_en = 0, n_hs = 0, n_br = 0;
        repeat (1600) begin
            tick();
            if (pe_d) begin
                n_en++;
                if (!hs_d) n_hs++;
                if (br_d) n_br++;
                for (int k = 0; k < 6; k++) begin
                    if (h_d == 10'(bh[k])) begin
                        n_total++;
                        if (hs_d !== exp_hs[k] || br_d !== exp_br[k]) begin
                            n_bad++;
                            $display("FAIL h_boundary h=%0d: got hs=%b br=%b, expected hs=%b br=%b",
                                     bh[k], hs_d, br_d, exp_hs[k], exp_br[k]);
                        end
                    end
                end
            end
        end
        n_total++;
        if (n_en != 800 || n_hs != 96 || n_br != 640) begin
            n_bad++;
            $display("FAIL line_counts: got en=%0d hs_low=%0d bright=%0d, expected en=800 hs_low=96 bright=640",
                     n_en, n_hs, n_br);
        end
    endtask

    task automatic test_h_wrap();
        logic found = 1'b0;
        for (int c = 0; c < 40000 && !found; c++) begin
            tick();
            if (pe_d && h_d == 10'd799 && v_d == 10'd10) found = 1'b1;
        end
        n_total++;
        if (!found) begin
            n_bad++;
            $display("FAIL h_wrap_reach: got timeout, expected h=799 v=10 within 40000 clk");
            return;
        end
        n_total++;
        if (br_d !== 1'b0 || hs_d !== 1'b1) begin
            n_bad++;
            $display("FAIL h_wrap_pre: got br=%b hs=%b, expected br=0 hs=1", br_d, hs_d);
        end
        tick();
        n_total++;
        if (h_d !== 10'd0 || v_d !== 10'd11 || pe_d !== 1'b0) begin
            n_bad++;
            $display("FAIL h_wrap: got h=%0d v=%0d pe=%b, expected h=0 v=11 pe=0", h_d, v_d, pe_d);
        end
    endtask

    task automatic test_reset_mid_line();
        logic found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            tick();
            if (pe_d && h_d == 10'd700) found = 1'b1;
        end
        n_total++;
        if (!found || hs_d !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_line_reach: got found=%b hs=%b, expected found=1 hs=0", found, hs_d);
            return;
        end
        rst_d = 1'b1;
        tick();
        n_total++;
        if ({pe_d, h_d, v_d, hs_d, vs_d, br_d} !== {1'b0, 10'd0, 10'd0, 3'b111}) begin
            n_bad++;
            $display("FAIL mid_line_reset: got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b, expected pe=0 h=0 v=0 hs=1 vs=1 br=1",
                     pe_d, h_d, v_d, hs_d, vs_d, br_d);
        end
    endtask

    task automatic test_v_wrap();
        logic found = 1'b0;
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            tick();
            if (pe_s && h_s == 10'd31 && v_s == 10'd16) found = 1'b1;
        end
        n_total++;
        if (!found || br_s !== 1'b0 || vs_s !== 1'b1) begin
            n_bad++;
            $display("FAIL v_wrap_reach: got found=%b br=%b vs=%b, expected found=1 br=0 vs=1", found, br_s, vs_s);
            return;
        end
        tick();
        n_total++;
        if (h_s !== 10'd0 || v_s !== 10'd0 || br_s !== 1'b1 || pe_s !== 1'b0) begin
            n_bad++;
            $display("FAIL v_wrap: got h=%0d v=%0d br=%b pe=%b, expected h=0 v=0 br=1 pe=0", h_s, v_s, br_s, pe_s);
        end
    endtask

    task automatic test_frame_counts();
        int   bv     [6] = '{9, 10, 11, 12, 14, 15};
        logic exp_vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_br [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int n_en = 0, n_hs = 0, n_vs = 0, n_br = 0;
        repeat (S_FRAME_CLK) begin
            tick();
            if (pe_s) begin
                n_en++;
                if (!hs_s) n_hs++;
                if (!vs_s) n_vs++;
                if (br_s) n_br++;
                if (h_s == 10'd0) begin
                    for (int k = 0; k < 6; k++) begin
                        if (v_s == 10'(bv[k])) begin
                            n_total++;
                            if (vs_s !== exp_vs[k] || br_s !== exp_br[k]) begin
                                n_bad++;
                                $display("FAIL v_boundary v=%0d: got vs=%b br=%b, expected vs=%b br=%b",
                                         bv[k], vs_s, br_s, exp_vs[k], exp_br[k]);
                            end
                        end
                    end
                end
            end
        end
        n_total++;
        if (n_en != 544 || n_hs != 85 || n_vs != 96 || n_br != 200) begin
            n_bad++;
            $display("FAIL frame_counts: got en=%0d hs_low=%0d vs_low=%0d bright=%0d, expected en=544 hs_low=85 vs_low=96 bright=200",
                     n_en, n_hs, n_vs, n_br);
        end
    endtask

`ifdef VGA_TIMING_FRAME_PULSE_EN
    task automatic test_frame_pulse();
        int n_pulse = 0;
        int t_first = -1, t_second = -1;
        for (int c = 0; c < 2 * S_FRAME_CLK; c++) begin
            tick();
            if (fs_s) begin
                n_pulse++;
                if (n_pulse == 1) t_first = c;
                if (n_pulse == 2) t_second = c;
                n_total++;
                if (pe_s !== 1'b1 || h_s !== 10'd0 || v_s !== 10'd10) begin
                    n_bad++;
                    $display("FAIL frame_pulse_pos: got pe=%b h=%0d v=%0d, expected pe=1 h=0 v=10", pe_s, h_s, v_s);
                end
            end
        end
        n_total++;
        if (n_pulse != 2 || (t_second - t_first) != S_FRAME_CLK) begin
            n_bad++;
            $display("FAIL frame_pulse_count: got pulses=%0d spacing=%0d, expected pulses=2 spacing=%0d",
                     n_pulse, t_second - t_first, S_FRAME_CLK);
        end
    endtask
`endif

    task automatic test_reset_in_sync();
        logic found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            tick();
            if (pe_s && h_s == 10'd25 && v_s == 10'd13) found = 1'b1;
        end
        n_total++;
        if (!found || hs_s !== 1'b0 || vs_s !== 1'b0) begin
            n_bad++;
            $display("FAIL sync_reach: got found=%b hs=%b vs=%b, expected found=1 hs=0 vs=0", found, hs_s, vs_s);
            return;
        end
        rst_s = 1'b1;
        tick();
        n_total++;
        if ({pe_s, h_s, v_s, hs_s, vs_s, br_s} !== {1'b0, 10'd0, 10'd0, 3'b111}) begin
            n_bad++;
            $display("FAIL sync_reset: got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b, expected pe=0 h=0 v=0 hs=1 vs=1 br=1",
                     pe_s, h_s, v_s, hs_s, vs_s, br_s);
        end
    endtask

    initial begin
        test_reset();
        test_hsync_line();
        test_h_wrap();
        test_reset_mid_line();
        test_v_wrap();
        test_frame_counts();
`ifdef VGA_TIMING_FRAME_PULSE_EN
        test_frame_pulse();
`endif
        test_reset_in_sync();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, meaning vertical porch and sync widths in lines.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single 50 MHz system clock, with all state on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-009 SHALL have port pixEn, output, 1 bit, meaning the 25 MHz pixel-rate enable.
REQ-010 SHALL have port hCount, output, 10 bits, meaning the current pixel column 0..799.
REQ-011 SHALL have port vCount, output, 10 bits, meaning the current line 0..524.
REQ-012 SHALL have port hSync, output, 1 bit, meaning horizontal sync, active low.
REQ-013 SHALL have port vSync, output, 1 bit, meaning vertical sync, active low.
REQ-014 SHALL have port bright, output, 1 bit, meaning the visible region, which downstream uses to gate rgbGen/rgbMem before the colour select.

Function
REQ-015 SHALL toggle pixEn every clk cycle, giving exactly one enabled cycle in every two.
REQ-016 SHALL change hCount and vCount only in cycles where pixEn=1.
REQ-017 SHALL increment hCount by 1 per enabled cycle and SHALL wrap it from H_TOTAL-1 (799) to 0.
REQ-018 SHALL increment vCount by 1 only in the enabled cycle where hCount wraps, and SHALL wrap it from V_TOTAL-1 (524) to 0 in that same cycle.
REQ-019 SHALL hold hSync low exactly while H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751), and high otherwise.
REQ-020 SHALL hold vSync low exactly while V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491), and high otherwise.
REQ-021 SHALL drive bright high exactly when hCount < H_VISIBLE and vCount < V_VISIBLE.
REQ-022 SHALL decode hSync, vSync and bright combinationally from the counter registers, with zero cycles of latency relative to hCount/vCount.
REQ-023 SHALL never let either counter leave its legal range, including after reset.

Reset
REQ-024 SHALL set pixEn=0, hCount=0 and vCount=0 on the first clk edge with reset=1; hSync, vSync and bright therefore read 1.
REQ-025 SHALL freeze all state while reset=1, and SHALL make reset asserted mid-line or mid-frame take effect on the next edge with no partial-line completion.
REQ-026 SHALL make pixEn=1 on the first edge after reset deasserts, and SHALL make hCount=1 on the following enabled edge.

Configuration
REQ-027 SHALL, with VGA_TIMING_FRAME_PULSE_EN defined, add output port frameStart (1 bit), high for exactly one clk cycle: the enabled cycle in which hCount=0 and vCount=V_VISIBLE (480).
REQ-028 SHALL, without VGA_TIMING_FRAME_PULSE_EN, omit frameStart and its logic entirely, with all other behaviour identical.

Structure
REQ-029 SHALL take H/V defaults and the derived H_TOTAL (800) and V_TOTAL (525) from shared package vga_pkg, which also holds the 10-bit count width constant.
REQ-030 SHALL instantiate one sub-module, vga_pix_en (the clock-enable divider), with the counters and decode in vga_timing.

Verification
REQ-031 SHALL cover reset held for 4 cycles then released -> pixEn sequence 1,0,1,0; hCount 0,1,1,2 on successive cycles; vCount=0.
REQ-032 SHALL cover running to hCount=799, vCount=10, then one enabled edge -> hCount=0, vCount=11.
REQ-033 SHALL cover running to hCount=799, vCount=524, then one enabled edge -> both counters 0, and bright=1.
REQ-034 SHALL cover one full frame (840000 clk) -> hSync low for 96 enabled cycles per line, vSync low for 2 lines (1600 enabled cycles), and bright high for 307200 enabled cycles.
REQ-035 SHALL cover reset asserted at hCount=700, vCount=491 -> next edge hSync=1, vSync=1, counters 0, pixEn 0.
REQ-036 SHALL cover, with VGA_TIMING_FRAME_PULSE_EN defined, 2 frames -> frameStart pulses exactly twice, each 1 cycle wide, 840000 clk apart.
